tia_horiz_counter: RTL and testbench

Horizontal sync counter for the TIA: a 6-bit polynomial (LFSR) counter advanced once per horizontal-phase clock, one count per 4 colour clocks, 57 counts per scan line. The decode logic turns counter states into the active-low set/reset strobes consumed directly by the downstream F1 SR flip-flops that hold HSYNC, HBLANK and colour-burst. The block also exports the raw count, a centre strobe and a line-wrap strobe.

---
 rtl/tia_horiz_counter_if.sv | 26 ++
 rtl/tia_horiz_counter.sv | 97 +++++++++
 tb/tb_tia_horiz_counter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tia_horiz_counter_if.sv
// Horizontal-counter bundle: restart/HMOVE controls in, count and F1 strobes out.
// Latency: none, wiring only.
// Backpressure: none; the strobes are consumed every cycle.
interface tia_horiz_counter_if;
    logic       rsync;
    logic       hmove_latch;
    logic [5:0] count;
    logic       shb_n;
    logic       rhb_n;
    logic       shs_n;
    logic       rhs_n;
    logic       scb_n;
    logic       rcb_n;
    logic       center;
    logic       wrap;

    modport master (
        output rsync, hmove_latch,
        input  count, shb_n, rhb_n, shs_n, rhs_n, scb_n, rcb_n, center, wrap
    );

    modport slave (
        input  rsync, hmove_latch,
        output count, shb_n, rhb_n, shs_n, rhs_n, scb_n, rcb_n, center, wrap
    );
endinterface

// File: rtl/tia_horiz_counter.sv
// TIA horizontal sync counter: 57-state LFSR line counter with registered F1 set/reset strobes.
// Latency: strobes are decoded from the next state, so they line up with the count they describe.
// Backpressure: none; advances on every clock edge.
module tia_horiz_counter (
    input  logic                 clock,
    input  logic                 reset,
    tia_horiz_counter_if.slave   hc
);

    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

    function automatic logic [5:0] state_at(input int n);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s = lfsr_next(s);
        return s;
    endfunction

    // Membership in the 57-state line; anything else (including the all-ones lockup) restarts.
    function automatic logic in_line(input logic [5:0] s);
        logic [5:0] t;
        logic       hit;
        t   = '0;
        hit = 1'b0;
        for (int i = 0; i < 57; i++) begin
            if (s == t) hit = 1'b1;
            t = lfsr_next(t);
        end
        return hit;
    endfunction

    localparam logic [5:0] S_HS_SET    = state_at(4);
    localparam logic [5:0] S_HS_RST    = state_at(8);
    localparam logic [5:0] S_CB_RST    = state_at(12);
    localparam logic [5:0] S_RHB_EARLY = state_at(16);
    localparam logic [5:0] S_RHB_LATE  = state_at(18);
    localparam logic [5:0] S_CENTER    = state_at(36);
    localparam logic [5:0] S_LAST      = state_at(56);

    logic [5:0] count_q;
    logic [5:0] count_d;
    logic       restart;
    logic       rhb_early;
    logic       rhb_late;
    logic       rhb_done_q;
    logic       shb_n_q, rhb_n_q, shs_n_q, rhs_n_q, scb_n_q, rcb_n_q;
    logic       center_q, wrap_q;

    always_comb begin
        restart   = hc.rsync || (count_q == S_LAST) || !in_line(count_q);
        count_d   = restart ? 6'd0 : lfsr_next(count_q);
        rhb_early = (count_d == S_RHB_EARLY) && !hc.hmove_latch && !rhb_done_q;
        rhb_late  = (count_d == S_RHB_LATE) && !rhb_done_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            rhb_done_q <= 1'b0;
            shb_n_q    <= 1'b1;
            rhb_n_q    <= 1'b1;
            shs_n_q    <= 1'b1;
            rhs_n_q    <= 1'b1;
            scb_n_q    <= 1'b1;
            rcb_n_q    <= 1'b1;
            center_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            shb_n_q  <= !restart;
            wrap_q   <= restart;
            shs_n_q  <= (count_d != S_HS_SET);
            rhs_n_q  <= (count_d != S_HS_RST);
            scb_n_q  <= (count_d != S_HS_RST);
            rcb_n_q  <= (count_d != S_CB_RST);
            center_q <= (count_d == S_CENTER);
            rhb_n_q  <= !(rhb_early || rhb_late);
            if (restart)
                rhb_done_q <= 1'b0;
            else if (rhb_early || rhb_late)
                rhb_done_q <= 1'b1;
        end
    end

    assign hc.count  = count_q;
    assign hc.shb_n  = shb_n_q;
    assign hc.rhb_n  = rhb_n_q;
    assign hc.shs_n  = shs_n_q;
    assign hc.rhs_n  = rhs_n_q;
    assign hc.scb_n  = scb_n_q;
    assign hc.rcb_n  = rcb_n_q;
    assign hc.center = center_q;
    assign hc.wrap   = wrap_q;

endmodule

// File: tb/tb_tia_horiz_counter.sv
// Scoreboard bench for tia_horiz_counter: a line-index model predicts every cycle's outputs.
module tb_tia_horiz_counter;

    logic clock = 1'b0;
    logic reset;

    tia_horiz_counter_if bus();

    tia_horiz_counter dut (
        .clock (clock),
        .reset (reset),
        .hc    (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0] count;
        logic       shb_n;
        logic       rhb_n;
        logic       shs_n;
        logic       rhs_n;
        logic       scb_n;
        logic       rcb_n;
        logic       center;
        logic       wrap;
    } obs_t;

    localparam obs_t RESET_OBS = '{count: 6'd0, shb_n: 1'b1, rhb_n: 1'b1, shs_n: 1'b1,
                                   rhs_n: 1'b1, scb_n: 1'b1, rcb_n: 1'b1, center: 1'b0,
                                   wrap: 1'b0};

    obs_t       exp_q[$];
    logic [5:0] seq[57];
    logic [5:0] first_states[13];
    int         n;
    bit         rhb_done;
    bit         inject_bad;
    int         checks = 0;
    int         errors = 0;

    function automatic obs_t sample();
        return {bus.count, bus.shb_n, bus.rhb_n, bus.shs_n, bus.rhs_n,
                bus.scb_n, bus.rcb_n, bus.center, bus.wrap};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: line position as an integer index, advanced by the line rules.
    initial begin
        obs_t e;
        bit   restart;
        n        = 0;
        rhb_done = 1'b0;
        for (int i = 0; i < 57; i++)
            seq[i] = (i == 0) ? 6'd0 : {seq[i-1][4:0], ~(seq[i-1][5] ^ seq[i-1][4])};
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                n        = 0;
                rhb_done = 1'b0;
                exp_q.delete();
            end else begin
                restart = bus.rsync || (n == 56) || inject_bad;
                if (restart) begin
                    n        = 0;
                    rhb_done = 1'b0;
                end else begin
                    n++;
                end
                e        = RESET_OBS;
                e.count  = seq[n];
                e.wrap   = restart;
                e.shb_n  = !restart;
                e.shs_n  = (n != 4);
                e.rhs_n  = (n != 8);
                e.scb_n  = (n != 8);
                e.rcb_n  = (n != 12);
                e.center = (n == 36);
                if (!rhb_done && ((n == 16 && !bus.hmove_latch) || n == 18)) begin
                    e.rhb_n  = 1'b0;
                    rhb_done = 1'b1;
                end
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare on the falling edge, away from the sampling edge.
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(negedge clock);
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard idx=%0d: got %h, expected %h", n, a, e);
                end
                checks++;
                if ((!a.shb_n && !a.rhb_n) || (!a.shs_n && !a.rhs_n) || (!a.scb_n && !a.rcb_n)) begin
                    errors++;
                    $display("FAIL pair_overlap idx=%0d: got %h, expected no set/reset pair low", n, a);
                end
            end
        end
    end

    task automatic wait_idx(input int k);
        int budget;
        budget = 0;
        do begin
            @(negedge clock);
            budget++;
        end while (n != k && budget < 200);
        if (n != k) begin
            checks++;
            errors++;
            $display("FAIL wait_idx: got index %0d, expected %0d within 200 cycles", n, k);
        end
    endtask

    initial begin
        first_states = '{6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111,
                         6'b011111, 6'b111110, 6'b111101, 6'b111011, 6'b110111,
                         6'b101111, 6'b011110, 6'b111100};
        bus.rsync       = 1'b0;
        bus.hmove_latch = 1'b0;
        inject_bad      = 1'b0;
        reset           = 1'b1;
        #22;
        chk("reset_state", 32'(sample()), 32'(RESET_OBS));

        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            chk($sformatf("first_state_N%0d", i), 32'(bus.count), 32'(first_states[i]));
        end

        // First natural wrap, then one clean line with hmove_latch low.
        wait_idx(0);
        chk("first_wrap", {bus.wrap, bus.shb_n}, 2'b10);
        wait_idx(0);

        // HMOVE held through N16, released entering N18 and entering N17.
        wait_idx(15);
        bus.hmove_latch = 1'b1;
        wait_idx(17);
        bus.hmove_latch = 1'b0;
        wait_idx(0);
        wait_idx(15);
        bus.hmove_latch = 1'b1;
        wait_idx(16);
        bus.hmove_latch = 1'b0;
        wait_idx(0);

        // RSYNC mid-line truncates the line.
        wait_idx(30);
        bus.rsync = 1'b1;
        @(negedge clock);
        bus.rsync = 1'b0;
        chk("rsync_restart", {bus.count, bus.wrap, bus.shb_n}, {6'd0, 2'b10});
        wait_idx(0);

        // RSYNC coinciding with the natural wrap.
        wait_idx(56);
        bus.rsync = 1'b1;
        @(negedge clock);
        bus.rsync = 1'b0;
        wait_idx(0);

        // Lockup state injected behind the counter's back.
        wait_idx(20);
        #1;
        force dut.count_q = 6'b111111;
        inject_bad = 1'b1;
        #1;
        release dut.count_q;
        @(negedge clock);
        inject_bad = 1'b0;
        chk("lockup_recovery", {bus.count, bus.wrap}, {6'd0, 1'b1});
        wait_idx(0);

        // Randomised restarts and HMOVE activity.
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            bus.rsync       = ($urandom_range(0, 79) == 0);
            bus.hmove_latch = ($urandom_range(0, 2) == 0);
        end
        bus.rsync       = 1'b0;
        bus.hmove_latch = 1'b0;

        // Asynchronous reset in the middle of N10.
        wait_idx(10);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'(sample()), 32'(RESET_OBS));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_first_edge", 32'(bus.count), 32'(6'b000001));
        wait_idx(0);
        wait_idx(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
